// File: rtl/hazard_unit.sv
// hazard_unit: pipeline control for the five-stage datapath.
// Drives the PC and inter-stage latch enables and bubble flushes. It resolves
// RAW hazards against the decode instruction, holds on data-memory misses,
// squashes wrong-path work on a taken branch or jump in MEM, and freezes on
// HALT. It also keeps saturating stall and flush counters.
// Build option: define HAZARD_FORWARD_EN when the datapath forwards from
// EX/MEM and MEM/WB; only load-use then needs a bubble.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [4:0]       idex_wsel,
  input  logic             idex_regWrite,
  input  logic             idex_dREN,
  input  logic [4:0]       exmem_wsel,
  input  logic             exmem_regWrite,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_taken,
  input  logic             exmem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, next_state;
  logic   memwait;
  logic   advance;
  logic   data_stall;
  logic   stall_inc;
  logic   flush_inc;

  // True when a stage writing wsel produces a register the decode instruction reads.
  function automatic logic raw_match(input logic       rw,
                                     input logic [4:0] wsel,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return rw && (wsel != 5'd0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign memwait = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign advance = ihit & ~memwait;

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers ALU results; only a load in EX cannot be forwarded in time.
  logic unused_exmem_fwd;
  assign unused_exmem_fwd = ^{exmem_wsel, exmem_regWrite};
  assign data_stall = idex_dREN &
                      raw_match(idex_regWrite, idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt);
`else
  // Without forwarding, any producer still in EX or MEM blocks decode.
  logic unused_idex_dren;
  assign unused_idex_dren = idex_dREN;
  assign data_stall = raw_match(idex_regWrite, idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt) |
                      raw_match(exmem_regWrite, exmem_wsel, ifid_rs, ifid_rt, ifid_uses_rt);
`endif

  // Priority decode of latch controls; everything idles in reset and in HALT.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    next_state  = state;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (nRST && (state == RUN)) begin
      if (memwait) begin
        // The whole pipe holds; a data stall hidden behind the miss counts once here.
        stall_inc = 1'b1;
      end else if (exmem_halt && advance) begin
        // Let the HALT retire through MEM/WB, squash everything younger.
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        next_state  = HALT;
      end else if (exmem_taken && advance) begin
        // Redirect: take the new PC, squash the three wrong-path slots.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (data_stall && advance) begin
        // Hold fetch and decode, push a bubble into EX.
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end else begin
        pc_en    = ihit;
        ifid_en  = ihit;
        idex_en  = ihit;
        exmem_en = ihit;
        memwb_en = ihit;
      end
    end
  end

  // State, halted flag and performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALT);
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage datapath. It is the producer of the enable and flush controls that every inter-stage latch (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) consumes. It detects data hazards against the instruction in decode, holds the pipe during data-memory misses, squashes wrong-path instructions when a branch or jump resolves in MEM, and freezes the pipe on HALT. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit, dhit  in  1  instruction and data cache hit.
- ifid_rs, ifid_rt  in  5  source registers of the instruction in IF/ID.
- ifid_uses_rt  in  1  the IF/ID instruction reads rt.
- idex_wsel  in  5  destination register in ID/EX.
- idex_regWrite, idex_dREN  in  1  ID/EX writes a register; ID/EX is a load.
- exmem_wsel  in  5  destination register in EX/MEM.
- exmem_regWrite, exmem_dREN, exmem_dWEN  in  1  EX/MEM register write, load, store.
- exmem_taken  in  1  branch taken or jump in EX/MEM.
- exmem_halt  in  1  HALT in EX/MEM.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous bubble insert.
- halted  out  1  pipeline frozen.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- FSM states are RUN and HALT. Reset enters RUN. RUN moves to HALT on an applied halt. HALT is sticky until nRST.
- Enables and flushes are combinational from the current inputs and state. State, `halted`, and the counters are registered.
- Definitions:
  - advance = ihit & !memwait.
  - memwait = (exmem_dREN | exmem_dWEN) & !dhit.
- RAW match vs stage X means X_regWrite, X_wsel != 0, and (X_wsel == ifid_rs or (ifid_uses_rt and X_wsel == ifid_rt)).
- Decisions in RUN, in priority order:
  1. memwait: all enables 0 and all flushes 0. The pipe holds.
  2. exmem_halt & advance:
     - memwb_en = 1.
     - ifid_flush = idex_flush = exmem_flush = 1.
     - pc_en = 0.
     - Next state is HALT.
  3. exmem_taken & advance:
     - pc_en = ifid_en = idex_en = exmem_en = memwb_en = 1.
     - ifid_flush = idex_flush = exmem_flush = 1.
     - flush_cnt increments.
  4. data stall & advance:
     - pc_en = ifid_en = 0.
     - idex_flush = 1 (bubble).
     - idex_en = exmem_en = memwb_en = 1.
     - stall_cnt increments.
  5. otherwise: every enable equals ihit and all flushes are 0.
- With !ihit and no memwait, all enables are 0. A branch, halt, or stall waits and is applied on the first cycle that advance is high. exmem_taken stays asserted because EX/MEM is held.
- A taken branch and a data stall in the same cycle: the flush wins and there is no stall. The stalled instruction is wrong-path.
- Memwait cycles also increment stall_cnt. A data stall stalled by memwait counts once, as memwait.
- HALT state: all enables 0, all flushes 0, halted = 1, counters frozen. Inputs are ignored.
- Counters saturate at all-ones with no wrap.

## Timing
- Controls are zero-latency, same cycle as the inputs.
- A stall or flush takes effect at the next rising edge, through the latches.
- Load-use with forwarding costs exactly 1 bubble cycle.
- A taken branch costs 3 squashed slots.
- halted rises one cycle after the applied halt edge.
- Reset (asynchronous, including mid-stall or mid-memwait):
  - State returns to RUN.
  - halted = 0 and stall_cnt = flush_cnt = 0 immediately.
  - While nRST = 0, all enables and flushes are forced to 0.

## Configuration
- HAZARD_FORWARD_EN defined:
  - The datapath forwards from EX/MEM and MEM/WB.
  - A data stall is a RAW match vs ID/EX with idex_dREN = 1 (load-use only).
- HAZARD_FORWARD_EN undefined:
  - A data stall is a RAW match vs ID/EX or EX/MEM, for any regWrite.
  - The register file writes in the first half-cycle, so WB needs no stall.
  - Up to 2 bubbles per dependence.

## Test plan
- Load-use: lw $3 in ID/EX, IF/ID add using rs = 3, ihit = 1, forwarding on -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt 0 -> 1; next cycle normal.
- No forwarding: add writing $5 in ID/EX, dependent in IF/ID -> 2 consecutive stall cycles, then advance. Writes to $0 never stall.
- Data miss: exmem_dREN = 1, dhit = 0 for 4 cycles -> all enables 0 for 4 cycles; stall_cnt += 4; dhit = 1 resumes.
- Branch with simultaneous load-use stall: exmem_taken = 1 -> flush of IF/ID, ID/EX, EX/MEM; pc_en = 1; no stall; flush_cnt += 1. With ihit = 0 the flush is delayed until ihit.
- Halt: exmem_halt = 1 with ihit -> memwb_en = 1 that cycle; halted = 1 next cycle; all enables 0 afterwards despite a taken branch.
- Counter saturation with CNT_W = 2 -> stall_cnt holds at 3. nRST low mid-memwait -> counters 0, halted 0, outputs 0 immediately.
